// File: rtl/ca_pkg.sv
// ca_pkg: shared cellular-automaton geometry, defaults and the row type.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package ca_pkg;

  localparam int CA_WIDTH = 80;  // cells per generation = display columns
  localparam int CA_ROWS  = 60;  // buffered generations = display rows

  typedef logic [CA_WIDTH-1:0] ca_row_t;

  // Generator defaults: Wolfram rule 30 grown from a single live cell in column 0.
  localparam logic [7:0] CA_RULE = 8'd30;
  localparam ca_row_t    CA_SEED = {1'b1, {(CA_WIDTH-1){1'b0}}};

  // Address width for an n-entry structure, never narrower than one bit.
  function automatic int ca_addr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ca_row_ram.sv
// ca_row_ram: DEPTH x WIDTH simple dual-port row store, one write port and one synchronous read port.
// Latency: rdata is valid the cycle after re; a same-address read and write returns the old row.
// Backpressure: none; both ports accept every cycle.
// Ports: clk; we/waddr/wdata write port; re/raddr read request; rdata registered read data.
// The array and read register are deliberately unreset so the store maps onto block RAM.
module ca_row_ram
  import ca_pkg::*;
#(
  parameter int WIDTH = CA_WIDTH,
  parameter int DEPTH = CA_ROWS,
  parameter int AW    = ca_addr_bits(CA_ROWS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Both ports in one process: the non-blocking write lands after the read
  // samples the array, which gives read-before-write on an address collision.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ca_scroll_buffer.sv
// ca_scroll_buffer: circular store of CA generations feeding the VGA pixel path, scrolling once full.
// Latency: a written row shows after the next frame_start; rd_en -> rd_pixel/rd_valid in 2 cycles, one read per cycle.
// Backpressure: wr_ready drops when the per-frame write budget is spent (or while frozen); reads never stall.
// Ports:
//   clk, rst            pixel clock; asynchronous active-high reset
//   wr_valid/wr_ready   generation handshake, wr_data bit WIDTH-1 is column 0
//   frame_start         one-cycle pulse at vertical blanking; commits the displayed origin and row count
//   rd_en/rd_row/rd_col pixel read request by display row/column
//   rd_pixel/rd_valid   registered cell value and its strobe, 2 cycles after rd_en
//   full                ROWS generations stored; the oldest row is displayed on top
// Build option: `CA_BUF_FREEZE_EN adds input freeze, which blocks writes and frame commits while high.
module ca_scroll_buffer
  import ca_pkg::*;
#(
  parameter int WIDTH         = CA_WIDTH,
  parameter int ROWS          = CA_ROWS,
  parameter int MAX_PER_FRAME = 0       // row writes per frame; 0 = unlimited
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             frame_start,
  input  logic             rd_en,
  input  logic [6:0]       rd_row,
  input  logic [6:0]       rd_col,
  output logic             rd_pixel,
  output logic             rd_valid,
  output logic             full
`ifdef CA_BUF_FREEZE_EN
  ,
  input  logic             freeze
`endif
);

  localparam int AW = ca_addr_bits(ROWS);          // row pointer
  localparam int CW = $clog2(ROWS + 1);            // row count, must hold ROWS
  localparam int XW = ca_addr_bits(WIDTH);         // bit index within a row
  localparam int BW = (MAX_PER_FRAME > 0) ? $clog2(MAX_PER_FRAME + 1) : 1;
  localparam int SW = ((AW > 7) ? AW : 7) + 1;     // disp_top + rd_row without overflow

  // ---------------------------------------------------------------- freeze
  logic freeze_w;
`ifdef CA_BUF_FREEZE_EN
  assign freeze_w = freeze;
`else
  assign freeze_w = 1'b0;
`endif

  // ---------------------------------------------------------------- write side state
  logic [AW-1:0] wp_q, wp_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] disp_top_q, disp_top_d;
  logic [CW-1:0] disp_count_q, disp_count_d;
  logic [BW-1:0] budget_q, budget_d;
  logic          budget_ok;
  logic          xfer;
  logic          commit;
  logic          full_d;
  logic [AW-1:0] top_d;

  assign budget_ok = (MAX_PER_FRAME == 0) || (budget_q != '0);
  assign wr_ready  = budget_ok && !freeze_w;
  assign xfer      = wr_valid && wr_ready;
  assign commit    = frame_start && !freeze_w;
  assign full      = (count_q == CW'(ROWS));

  always_comb begin
    wp_d         = wp_q;
    count_d      = count_q;
    budget_d     = budget_q;
    disp_top_d   = disp_top_q;
    disp_count_d = disp_count_q;
    full_d       = 1'b0;
    top_d        = '0;

    if (xfer) begin
      wp_d = (wp_q == AW'(ROWS - 1)) ? '0 : wp_q + 1'b1;
      if (count_q != CW'(ROWS)) begin
        count_d = count_q + 1'b1;
      end
      if (MAX_PER_FRAME > 0) begin
        budget_d = budget_q - 1'b1;
      end
    end

    // Once full, the next slot to be overwritten holds the oldest row.
    full_d = (count_d == CW'(ROWS));
    top_d  = full_d ? wp_d : '0;

    // Commit sees this cycle's write too, and its reload overrides the decrement.
    if (commit) begin
      disp_top_d   = top_d;
      disp_count_d = count_d;
      budget_d     = BW'(MAX_PER_FRAME);
    end
  end

  // ---------------------------------------------------------------- read stage 1
  logic [SW-1:0]    sum_w;
  logic [AW-1:0]    phys_w;
  logic             blank_w;
  logic [6:0]       col_w;
  logic [WIDTH-1:0] ram_rd_dat;

  assign blank_w = (32'(rd_row) >= 32'(disp_count_q)) ||
                   (32'(rd_row) >= ROWS) ||
                   (32'(rd_col) >= WIDTH);
  assign sum_w   = SW'(disp_top_q) + SW'(rd_row);
  assign col_w   = blank_w ? 7'd0 : rd_col;

  // With rd_row and disp_top both below ROWS the sum is under 2*ROWS, so one
  // conditional subtract is the whole modulo. Blank reads park on row 0.
  always_comb begin
    phys_w = '0;
    if (!blank_w) begin
      phys_w = (sum_w >= SW'(ROWS)) ? AW'(sum_w - SW'(ROWS)) : AW'(sum_w);
    end
  end

  ca_row_ram #(
    .WIDTH (WIDTH),
    .DEPTH (ROWS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (xfer),
    .waddr (wp_q),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr (phys_w),
    .rdata (ram_rd_dat)
  );

  // ---------------------------------------------------------------- read stage 2
  logic          s1_vld_q;
  logic          s1_blank_q;
  logic [6:0]    s1_col_q;
  logic          rd_pixel_q;
  logic          rd_valid_q;
  logic [XW-1:0] bit_idx;

  // Column 0 is the MSB of the stored row.
  assign bit_idx  = XW'(WIDTH - 1) - XW'(s1_col_q);
  assign rd_pixel = rd_pixel_q;
  assign rd_valid = rd_valid_q;

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q         <= '0;
      count_q      <= '0;
      disp_top_q   <= '0;
      disp_count_q <= '0;
      budget_q     <= BW'(MAX_PER_FRAME);
      s1_vld_q     <= 1'b0;
      s1_blank_q   <= 1'b1;
      s1_col_q     <= '0;
      rd_pixel_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      wp_q         <= wp_d;
      count_q      <= count_d;
      disp_top_q   <= disp_top_d;
      disp_count_q <= disp_count_d;
      budget_q     <= budget_d;
      s1_vld_q     <= rd_en;
      s1_blank_q   <= blank_w;
      s1_col_q     <= col_w;
      rd_valid_q   <= s1_vld_q;
      rd_pixel_q   <= s1_vld_q && !s1_blank_q && ram_rd_dat[bit_idx];
    end
  end

endmodule
